// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare/bimodal branch direction predictor with speculative GHR and commit-time repair
module gshare_predictor #(
  parameter int IDX_WIDTH = 6,
  parameter int CNT_WIDTH = 2,
  parameter int CNT_INIT  = 1,
  parameter int GHR_WIDTH = 6,
  parameter int MODE      = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 if_valid,
  input  logic [31:0]          pc_in,
  output logic                 pred2if_result,
  output logic [GHR_WIDTH-1:0] pred2if_ghr,
  input  logic                 rob_valid,
  input  logic [31:0]          rob_instr_addr,
  input  logic                 rob_is_jump,
  input  logic [GHR_WIDTH-1:0] rob_ghr,
  input  logic                 rob_mispredict,
  output logic [31:0]          perf_commit_cnt,
  output logic [31:0]          perf_mispred_cnt
);

  localparam int                   DEPTH   = 1 << IDX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'(CNT_INIT);

  logic [CNT_WIDTH-1:0] cnt_q [DEPTH];
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic [GHR_WIDTH-1:0] ghr_shift, ghr_repair;
  logic [31:0]          commit_q, commit_d;
  logic [31:0]          mispred_q, mispred_d;
  logic [IDX_WIDTH-1:0] pred_idx, train_idx;
  logic [CNT_WIDTH-1:0] train_cur, train_nxt;
  logic                 train_en;
  logic                 repair_en;
  logic                 unused_bits;

  generate
    if (MODE != 0) begin : g_gshare
      assign pred_idx  = pc_in[IDX_WIDTH+1:2] ^ IDX_WIDTH'(ghr_q);
      assign train_idx = rob_instr_addr[IDX_WIDTH+1:2] ^ IDX_WIDTH'(rob_ghr);
    end else begin : g_bimodal
      assign pred_idx  = pc_in[IDX_WIDTH+1:2];
      assign train_idx = rob_instr_addr[IDX_WIDTH+1:2];
    end

    if (GHR_WIDTH == 1) begin : g_ghr_one
      assign ghr_shift  = pred2if_result;
      assign ghr_repair = rob_is_jump;
    end else begin : g_ghr_wide
      assign ghr_shift  = {ghr_q[GHR_WIDTH-2:0], pred2if_result};
      assign ghr_repair = {rob_ghr[GHR_WIDTH-2:0], rob_is_jump};
    end
  endgenerate

  assign unused_bits = ^{pc_in[31:IDX_WIDTH+2], pc_in[1:0],
                         rob_instr_addr[31:IDX_WIDTH+2], rob_instr_addr[1:0], rob_ghr};

  assign pred2if_result   = cnt_q[pred_idx][CNT_WIDTH-1];
  assign pred2if_ghr      = ghr_q;
  assign perf_commit_cnt  = commit_q;
  assign perf_mispred_cnt = mispred_q;

  assign train_en  = rdy_in & rob_valid;
  assign repair_en = train_en & rob_mispredict;
  assign train_cur = cnt_q[train_idx];

  always_comb begin
    train_nxt = train_cur;
    if (rob_is_jump) begin
      if (train_cur != CNT_MAX) train_nxt = train_cur + CNT_WIDTH'(1);
    end else begin
      if (train_cur != '0) train_nxt = train_cur - CNT_WIDTH'(1);
    end
  end

  // A mispredict flushes IF, so its same-cycle speculative shift is dropped.
  always_comb begin
    ghr_d     = ghr_q;
    commit_d  = commit_q;
    mispred_d = mispred_q;
    if (rdy_in) begin
      if (repair_en)     ghr_d = ghr_repair;
      else if (if_valid) ghr_d = ghr_shift;
    end
    if (train_en)  commit_d  = commit_q + 32'd1;
    if (repair_en) mispred_d = mispred_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RST;
    end else if (train_en) begin
      cnt_q[train_idx] <= train_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ghr_q     <= '0;
      commit_q  <= '0;
      mispred_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      commit_q  <= commit_d;
      mispred_q <= mispred_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - scoreboard bench for gshare_predictor, gshare and bimodal instances side by side
module tb_gshare_predictor;

  localparam int IW = 4;
  localparam int GW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n, rdy, if_valid, rob_valid, rob_is_jump, rob_mispredict;
  logic [31:0]   pc, rob_addr;
  logic [GW-1:0] rob_ghr;
  logic          res1, res0;
  logic [GW-1:0] ghr1, ghr0;
  logic [31:0]   cc1, cc0, mc1, mc0;

  always #5 clk = ~clk;

  gshare_predictor #(.IDX_WIDTH(IW), .CNT_WIDTH(CW), .CNT_INIT(1), .GHR_WIDTH(GW), .MODE(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .if_valid(if_valid), .pc_in(pc),
    .pred2if_result(res1), .pred2if_ghr(ghr1), .rob_valid(rob_valid), .rob_instr_addr(rob_addr),
    .rob_is_jump(rob_is_jump), .rob_ghr(rob_ghr), .rob_mispredict(rob_mispredict),
    .perf_commit_cnt(cc1), .perf_mispred_cnt(mc1));

  gshare_predictor #(.IDX_WIDTH(IW), .CNT_WIDTH(CW), .CNT_INIT(1), .GHR_WIDTH(GW), .MODE(0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .if_valid(if_valid), .pc_in(pc),
    .pred2if_result(res0), .pred2if_ghr(ghr0), .rob_valid(rob_valid), .rob_instr_addr(rob_addr),
    .rob_is_jump(rob_is_jump), .rob_ghr(rob_ghr), .rob_mispredict(rob_mispredict),
    .perf_commit_cnt(cc0), .perf_mispred_cnt(mc0));

  typedef struct {
    logic [GW-1:0] ghr1;
    logic [GW-1:0] ghr0;
    logic [31:0]   commit;
    logic [31:0]   mis;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] m_cnt [2][16];
  logic [GW-1:0] m_ghr [2];
  logic [31:0]   m_commit, m_mis;

  function automatic logic [IW-1:0] m_idx(int mode, logic [31:0] a, logic [GW-1:0] h);
    logic [IW-1:0] base;
    base = a[IW+1:2];
    return (mode != 0) ? (base ^ IW'(h)) : base;
  endfunction

  function automatic logic m_pred(int mode, logic [31:0] a);
    logic [CW-1:0] c;
    c = m_cnt[mode][m_idx(mode, a, m_ghr[mode])];
    return c[CW-1];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) m_cnt[m][i] = CW'(1);
      m_ghr[m] = '0;
    end
    m_commit = '0;
    m_mis    = '0;
  endtask

  task automatic idle();
    rdy = 1'b1; if_valid = 1'b0; rob_valid = 1'b0; rob_mispredict = 1'b0;
    rob_is_jump = 1'b0; rob_ghr = '0; rob_addr = '0;
  endtask

  // Advance the model for the inputs now applied, queue the post-edge expectation, then clock.
  task automatic tick();
    exp_t          e;
    logic          p [2];
    logic [IW-1:0] ti;
    logic [CW-1:0] c;
    for (int m = 0; m < 2; m++) p[m] = m_pred(m, pc);
    if (rdy) begin
      for (int m = 0; m < 2; m++) begin
        if (rob_valid) begin
          ti = m_idx(m, rob_addr, rob_ghr);
          c  = m_cnt[m][ti];
          if (rob_is_jump && c != '1) c = c + CW'(1);
          else if (!rob_is_jump && c != '0) c = c - CW'(1);
          m_cnt[m][ti] = c;
        end
        if (rob_valid && rob_mispredict) m_ghr[m] = {rob_ghr[GW-2:0], rob_is_jump};
        else if (if_valid)               m_ghr[m] = {m_ghr[m][GW-2:0], p[m]};
      end
      if (rob_valid) m_commit = m_commit + 32'd1;
      if (rob_valid && rob_mispredict) m_mis = m_mis + 32'd1;
    end
    e.ghr1 = m_ghr[1]; e.ghr0 = m_ghr[0]; e.commit = m_commit; e.mis = m_mis;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; idle(); pc = 32'h0; model_reset();
    #2;
    total++; if (ghr1 !== 4'b0000) begin bad++; $display("FAIL reset_ghr got=%b exp=0000", ghr1); end
    total++; if (cc1 !== 32'd0 || mc1 !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", cc1, mc1); end
    total++; if (res1 !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b exp=0", res1); end
    @(negedge clk); rst_n = 1'b1;
    rob_valid = 1'b1; rob_mispredict = 1'b1; rob_is_jump = 1'b1; rob_addr = 32'h14; rob_ghr = 4'b0111;
    tick(); tick();
    e = exp_q.pop_front(); e = exp_q.pop_front();
    total++; if (cc1 !== e.commit || mc1 !== e.mis) begin bad++; $display("FAIL dirty_perf got=%0d/%0d exp=%0d/%0d", cc1, mc1, e.commit, e.mis); end
    total++; if (ghr1 !== 4'b1111) begin bad++; $display("FAIL dirty_ghr got=%b exp=1111", ghr1); end
    #2 rst_n = 1'b0; pc = 32'h08;
    #1;
    total++; if (ghr1 !== 4'b0000 || ghr0 !== 4'b0000) begin bad++; $display("FAIL mid_reset_ghr got=%b/%b exp=0000", ghr1, ghr0); end
    total++; if (cc1 !== 32'd0 || mc1 !== 32'd0) begin bad++; $display("FAIL mid_reset_perf got=%0d/%0d exp=0/0", cc1, mc1); end
    total++; if (res1 !== 1'b0) begin bad++; $display("FAIL mid_reset_cnt_gshare got=%b exp=0", res1); end
    pc = 32'h14; #1;
    total++; if (res0 !== 1'b0) begin bad++; $display("FAIL mid_reset_cnt_bimodal got=%b exp=0", res0); end
    model_reset();
    @(posedge clk); #1;
    total++; if (cc1 !== 32'd0) begin bad++; $display("FAIL reset_held_edge got=%0d exp=0", cc1); end
    idle();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    exp_t          e;
    logic [CW-1:0] seq [7];
    seq = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    idle(); pc = 32'h10;
    rob_valid = 1'b1; rob_addr = 32'h10; rob_ghr = '0;
    for (int i = 0; i < 7; i++) begin
      rob_is_jump = (i < 3);
      tick();
      e = exp_q.pop_front();
      total++; if (dut.cnt_q[4] !== seq[i] || dut0.cnt_q[4] !== seq[i]) begin
        bad++; $display("FAIL sat_cnt[%0d] got=%0d/%0d exp=%0d", i, dut.cnt_q[4], dut0.cnt_q[4], seq[i]); end
      total++; if (res1 !== seq[i][1]) begin bad++; $display("FAIL sat_pred[%0d] got=%b exp=%b", i, res1, seq[i][1]); end
      total++; if (cc1 !== e.commit) begin bad++; $display("FAIL sat_commit[%0d] got=%0d exp=%0d", i, cc1, e.commit); end
    end
    idle();
  endtask

  task automatic test_shift_repair();
    exp_t e;
    idle();
    rob_valid = 1'b1; rob_addr = 32'h00; rob_ghr = '0; rob_is_jump = 1'b1;
    tick(); tick();
    e = exp_q.pop_front(); e = exp_q.pop_front();
    idle(); pc = 32'h00; if_valid = 1'b1; #1;
    total++; if (res1 !== 1'b1) begin bad++; $display("FAIL shift_pred0 got=%b exp=1", res1); end
    tick(); e = exp_q.pop_front();
    pc = 32'h04; #1;
    total++; if (res1 !== 1'b1) begin bad++; $display("FAIL shift_pred1 got=%b exp=1", res1); end
    tick(); e = exp_q.pop_front();
    total++; if (ghr1 !== 4'b0011) begin bad++; $display("FAIL shift_ghr got=%b exp=0011", ghr1); end
    total++; if (ghr0 !== e.ghr0) begin bad++; $display("FAIL shift_ghr_bimodal got=%b exp=%b", ghr0, e.ghr0); end
    rob_valid = 1'b1; rob_mispredict = 1'b1; rob_ghr = 4'b0101; rob_is_jump = 1'b0; rob_addr = 32'h3C;
    tick(); e = exp_q.pop_front();
    total++; if (ghr1 !== 4'b1010 || ghr0 !== 4'b1010) begin bad++; $display("FAIL repair_ghr got=%b/%b exp=1010", ghr1, ghr0); end
    total++; if (mc1 !== 32'd1 || mc0 !== 32'd1) begin bad++; $display("FAIL repair_mis got=%0d/%0d exp=1", mc1, mc0); end
    idle();
  endtask

  task automatic test_gshare_index();
    exp_t e;
    idle();
    rob_valid = 1'b1; rob_mispredict = 1'b1; rob_ghr = 4'b0010; rob_is_jump = 1'b0; rob_addr = 32'h20;
    tick(); e = exp_q.pop_front();
    total++; if (ghr1 !== 4'b0100) begin bad++; $display("FAIL gs_repair_ghr got=%b exp=0100", ghr1); end
    rob_mispredict = 1'b0; rob_ghr = '0; rob_is_jump = 1'b1; rob_addr = 32'h00;
    tick(); tick();
    e = exp_q.pop_front(); e = exp_q.pop_front();
    total++; if (ghr1 !== 4'b0100) begin bad++; $display("FAIL gs_train_ghr got=%b exp=0100", ghr1); end
    idle(); pc = 32'h10; #1;
    total++; if (res1 !== 1'b1) begin bad++; $display("FAIL gs_pred_gshare got=%b exp=1", res1); end
    total++; if (res0 !== 1'b0) begin bad++; $display("FAIL gs_pred_bimodal got=%b exp=0", res0); end
  endtask

  task automatic test_rdy_low();
    exp_t e;
    idle(); rdy = 1'b0; if_valid = 1'b1;
    rob_valid = 1'b1; rob_mispredict = 1'b1; rob_is_jump = 1'b1; rob_addr = 32'h10; rob_ghr = '0;
    pc = 32'h10;
    for (int i = 0; i < 5; i++) begin
      tick(); e = exp_q.pop_front();
      total++; if (ghr1 !== e.ghr1 || ghr0 !== e.ghr0) begin bad++; $display("FAIL rdy_ghr[%0d] got=%b/%b exp=%b/%b", i, ghr1, ghr0, e.ghr1, e.ghr0); end
      total++; if (cc1 !== e.commit || mc1 !== e.mis) begin bad++; $display("FAIL rdy_perf[%0d] got=%0d/%0d exp=%0d/%0d", i, cc1, mc1, e.commit, e.mis); end
      total++; if (dut0.cnt_q[4] !== 2'd0) begin bad++; $display("FAIL rdy_cnt[%0d] got=%0d exp=0", i, dut0.cnt_q[4]); end
    end
    pc = 32'h00; #1;
    total++; if (res0 !== m_pred(0, pc) || res1 !== m_pred(1, pc)) begin
      bad++; $display("FAIL rdy_comb_pred got=%b/%b exp=%b/%b", res0, res1, m_pred(0, pc), m_pred(1, pc)); end
    idle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      rdy            = ($urandom_range(0, 7) != 0);
      if_valid       = $urandom_range(0, 1);
      rob_valid      = $urandom_range(0, 1);
      rob_mispredict = ($urandom_range(0, 3) == 0);
      rob_is_jump    = $urandom_range(0, 1);
      rob_ghr        = GW'($urandom_range(0, 15));
      rob_addr       = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      pc             = (i % 5 == 0) ? rob_addr : {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      #1;
      total++; if (res1 !== m_pred(1, pc) || res0 !== m_pred(0, pc)) begin
        bad++; $display("FAIL b2b_pred[%0d] got=%b/%b exp=%b/%b", i, res1, res0, m_pred(1, pc), m_pred(0, pc)); end
      tick(); e = exp_q.pop_front();
      total++; if (ghr1 !== e.ghr1 || ghr0 !== e.ghr0) begin bad++; $display("FAIL b2b_ghr[%0d] got=%b/%b exp=%b/%b", i, ghr1, ghr0, e.ghr1, e.ghr0); end
      total++; if (cc1 !== e.commit || cc0 !== e.commit || mc1 !== e.mis || mc0 !== e.mis) begin
        bad++; $display("FAIL b2b_perf[%0d] got=%0d/%0d exp=%0d/%0d", i, cc1, mc1, e.commit, e.mis); end
    end
    idle();
  endtask

  task automatic test_perf_wrap();
    exp_t e;
    idle();
    @(negedge clk);
    force dut.commit_q = 32'hFFFF_FFFF;
    #1 release dut.commit_q;
    #1;
    total++; if (cc1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preset got=%h exp=ffffffff", cc1); end
    rob_valid = 1'b1; rob_addr = 32'h08;
    tick(); e = exp_q.pop_front();
    total++; if (cc1 !== 32'd0) begin bad++; $display("FAIL wrap_commit got=%h exp=00000000", cc1); end
    total++; if (mc1 !== e.mis || cc0 !== e.commit) begin bad++; $display("FAIL wrap_others got=%0d/%0d exp=%0d/%0d", mc1, cc0, e.mis, e.commit); end
    idle();
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_shift_repair();
    test_gshare_index();
    test_rdy_low();
    test_back_to_back();
    test_perf_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised branch direction predictor for the IF stage. Keeps a table of saturating counters indexed by PC, optionally XOR-folded with a speculative global history register (GHR). IF gets the prediction and the GHR snapshot combinationally. The ROB returns the outcome, the snapshot and the mispredict flag at commit, to train the table and repair history. Successor to the fixed 2-bit bimodal predictor, which is the MODE=0 case.

## Interface
- IDX_WIDTH, 6: log2 of table depth (2^IDX_WIDTH counters)
- CNT_WIDTH, 2: counter width, legal range 2..4
- CNT_INIT, 1: counter reset value (weakly not-taken at CNT_WIDTH=2)
- GHR_WIDTH, 6: history length, 1..IDX_WIDTH
- MODE, 1: 0 = bimodal (history ignored for indexing), 1 = gshare
- Reset is asynchronous and active-low (`rst_n_in`); design runs on one clock (`clk_in`).
- clk_in  in  1  clock, all state on rising edge
- rst_n_in  in  1  async active-low reset
- rdy_in  in  1  global ready; when low, all state is frozen
- if_valid  in  1  IF is consuming a prediction for a branch this cycle
- pc_in  in  32  fetch PC
- pred2if_result  out  1  predicted taken (combinational)
- pred2if_ghr  out  GHR_WIDTH  current speculative GHR; IF carries it with the instruction
- rob_valid  in  1  a branch commits this cycle
- rob_instr_addr  in  32  PC of the committing branch
- rob_is_jump  in  1  actual outcome (1 = taken)
- rob_ghr  in  GHR_WIDTH  GHR snapshot recorded at that branch's prediction
- rob_mispredict  in  1  that branch was mispredicted; qualified by rob_valid
- perf_commit_cnt  out  32  committed branches
- perf_mispred_cnt  out  32  committed mispredictions

## Operation
- Index function, f(pc, h):
  - MODE=1: pc[IDX_WIDTH+1:2] XOR zero-extend(h)
  - MODE=0: pc[IDX_WIDTH+1:2]
- Predict: pred2if_result = MSB of counter[f(pc_in, spec_ghr)]; pred2if_ghr = spec_ghr. Pure combinational read of current state.
- Speculative history:
  - On if_valid, spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], pred2if_result}.
  - GHR_WIDTH=1: spec_ghr <= pred2if_result.
- Train: on rob_valid, update counter[f(rob_instr_addr, rob_ghr)].
  - Taken: +1, saturating at 2^CNT_WIDTH-1.
  - Not taken: -1, saturating at 0.
  - Always uses the returned snapshot, never the live GHR.
- Repair: on rob_valid && rob_mispredict, spec_ghr <= {rob_ghr[GHR_WIDTH-2:0], rob_is_jump}.
- Perf:
  - perf_commit_cnt +1 per rob_valid.
  - perf_mispred_cnt +1 per rob_valid && rob_mispredict.
  - Both wrap modulo 2^32.
- No FSM beyond the registers above. State = counter array, spec_ghr, two perf counters.

## Timing
- Reset (async, rst_n_in=0):
  - every counter = CNT_INIT
  - spec_ghr = 0
  - perf counters = 0
  - outputs follow immediately: pred2if_ghr=0; pred2if_result = MSB of CNT_INIT (0 by default)
  - Release is sampled at the next rising edge; no update happens on the release edge if rst_n_in is still low at that edge.
- Prediction latency 0 cycles. Training and history effects are visible from the cycle after the edge.
- Simultaneous events:
  - Repair and if_valid in the same cycle: repair wins; that if_valid shift is discarded, since IF is being flushed.
  - Training and prediction of the same index in the same cycle: prediction returns the pre-update value.
  - Training with rob_ghr differing from spec_ghr is legal and expected.
- rdy_in=0: no counter, GHR or perf update regardless of if_valid/rob_valid. Combinational outputs still track pc_in and state.
- Reset mid-operation discards all training and in-flight history. IF/ROB are flushed by the same reset.

## Test plan
- Reset with IDX_WIDTH=4, GHR_WIDTH=4, CNT_WIDTH=2, MODE=1:
  - pulse rst_n_in low between clock edges -> pred2if_ghr=0 and perf counters=0 immediately, before the next edge
  - any pc_in -> pred2if_result=0
- Saturation:
  - commit addr 0x10, rob_ghr=0, taken, 3 times -> counter[4] goes 1→2→3→3; pred for pc 0x10 (spec_ghr=0) becomes 1 after the first commit
  - then 4 not-taken -> counter goes 3→2→1→0→0; pred=0
- Speculative shift and repair:
  - two if_valid with predicted 1 -> pred2if_ghr=0b0011
  - rob_valid+rob_mispredict, rob_ghr=0b0101, taken=0, with if_valid high the same cycle -> pred2if_ghr=0b1010 next cycle; perf_mispred_cnt=1
- gshare indexing:
  - train addr 0x00 / rob_ghr 0 taken twice, leaving spec_ghr=0b0100 after the training commits
  - pc 0x10 (idx 4^4=0) -> pred=1
  - same PC with MODE=0 -> pred=0
- rdy_in=0 for 5 cycles with rob_valid and if_valid asserted -> counters, GHR and perf counters unchanged
- Perf wrap: force perf_commit_cnt to 0xFFFFFFFF, one commit -> 0
